// File: rtl/vga_timing_gen_if.sv
// Output bundle of the VGA timing generator: pixel enable in, timing and position out.
// FRAME_CNT exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
  parameter int HC_W = 10,
  parameter int VC_W = 10,
  parameter int PC_W = 19
);
  logic            CE;
  logic            PIXEL;
  logic            VGA_HS;
  logic            VGA_VS;
  logic [HC_W-1:0] H_CNT;
  logic [VC_W-1:0] V_CNT;
  logic [PC_W-1:0] P_COUNT;
  logic            LINE_START;
  logic            FRAME_START;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0]      FRAME_CNT;
`endif

`ifdef VGA_FRAME_CNT_EN
  modport master (
    input  CE,
    output PIXEL, VGA_HS, VGA_VS, H_CNT, V_CNT, P_COUNT, LINE_START, FRAME_START, FRAME_CNT
  );
  modport slave (
    output CE,
    input  PIXEL, VGA_HS, VGA_VS, H_CNT, V_CNT, P_COUNT, LINE_START, FRAME_START, FRAME_CNT
  );
`else
  modport master (
    input  CE,
    output PIXEL, VGA_HS, VGA_VS, H_CNT, V_CNT, P_COUNT, LINE_START, FRAME_START
  );
  modport slave (
    output CE,
    input  PIXEL, VGA_HS, VGA_VS, H_CNT, V_CNT, P_COUNT, LINE_START, FRAME_START
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with pixel clock-enable, sync polarity and start strobes.
// Optional 8-bit frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HC_W     = 10,
  parameter int VC_W     = 10,
  parameter int PC_W     = 19
) (
  input  logic VGA_CLK,
  input  logic RST,
  vga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT    = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] HS_BEGIN = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_ACT    = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] VS_BEGIN = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END   = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [HC_W-1:0] h_cnt_reg, h_cnt_next;
  logic [VC_W-1:0] v_cnt_reg, v_cnt_next;
  logic [PC_W-1:0] p_cnt_reg, p_cnt_next;
  logic            pixel_reg, pixel_next;
  logic            hs_reg, hs_next;
  logic            vs_reg, vs_next;
  logic            line_start_reg, frame_start_reg;
  logic            at_line_start, at_origin;

  // Position one step ahead; everything below is decoded from it so outputs align with the counters.
  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    at_line_start = (h_cnt_next == '0);
    at_origin     = at_line_start && (v_cnt_next == '0);
    pixel_next    = (h_cnt_next < H_ACT) && (v_cnt_next < V_ACT);
    hs_next       = ((h_cnt_next >= HS_BEGIN) && (h_cnt_next < HS_END)) ? HS_POL : ~HS_POL;
    vs_next       = ((v_cnt_next >= VS_BEGIN) && (v_cnt_next < VS_END)) ? VS_POL : ~VS_POL;
    // Index advances only when landing on an active pixel, so it holds through blanking.
    p_cnt_next    = p_cnt_reg;
    if (at_origin) begin
      p_cnt_next = '0;
    end else if (pixel_next) begin
      p_cnt_next = p_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge VGA_CLK or negedge RST) begin
    if (!RST) begin
      h_cnt_reg       <= H_LAST;
      v_cnt_reg       <= V_LAST;
      p_cnt_reg       <= '0;
      pixel_reg       <= 1'b0;
      hs_reg          <= ~HS_POL;
      vs_reg          <= ~VS_POL;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= bus.CE && at_line_start;
      frame_start_reg <= bus.CE && at_origin;
      if (bus.CE) begin
        h_cnt_reg <= h_cnt_next;
        v_cnt_reg <= v_cnt_next;
        p_cnt_reg <= p_cnt_next;
        pixel_reg <= pixel_next;
        hs_reg    <= hs_next;
        vs_reg    <= vs_next;
      end
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt_reg;

  always_ff @(posedge VGA_CLK or negedge RST) begin
    if (!RST) begin
      frame_cnt_reg <= 8'd0;
    end else if (bus.CE && at_origin) begin
      frame_cnt_reg <= frame_cnt_reg + 8'd1;
    end
  end

  assign bus.FRAME_CNT = frame_cnt_reg;
`endif

  assign bus.H_CNT       = h_cnt_reg;
  assign bus.V_CNT       = v_cnt_reg;
  assign bus.P_COUNT     = p_cnt_reg;
  assign bus.PIXEL       = pixel_reg;
  assign bus.VGA_HS      = hs_reg;
  assign bus.VGA_VS      = vs_reg;
  assign bus.LINE_START  = line_start_reg;
  assign bus.FRAME_START = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance and a tiny 8x6 instance share
// clock, reset and CE; frame-level behaviour is checked on the tiny one.
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic ce;

  int n_checks = 0;
  int n_fail   = 0;

  vga_timing_gen_if #(.HC_W(10), .VC_W(10), .PC_W(19)) d_if ();
  vga_timing_gen_if #(.HC_W(3),  .VC_W(3),  .PC_W(4))  s_if ();

  assign d_if.CE = ce;
  assign s_if.CE = ce;

  vga_timing_gen dut_default (
    .VGA_CLK (clk),
    .RST     (rst_n),
    .bus     (d_if)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0),
    .HC_W(3), .VC_W(3), .PC_W(4)
  ) dut_small (
    .VGA_CLK (clk),
    .RST     (rst_n),
    .bus     (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Line-0 statistics for the default instance
  int d_hs_low, d_hs_first, d_hs_last, d_pix_cnt, d_pix_off_first;
  int d_p639, d_p799, d_vs_low, d_ls_sum, d_fs_sum;
  // Frame statistics for the small instance
  int s_hs_err, s_vs_err, s_pix_err, s_pmax, s_fs_cnt, s_ls_cnt, s_gap_err, s_last_fs, s_wrap_err;
  int s_p_3_2, s_p_0_1, s_p_7_5;
  // CE toggle statistics
  int d_moves, s_moves, s_width_err, s_ls_width_err;
  logic [9:0] d_prev_h;
  logic [2:0] s_prev_h;
  logic s_prev_fs, s_prev_ls;
  bit found;

  initial begin
    rst_n = 1'b0;
    ce    = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_d_h", d_if.H_CNT, 799);
    check("rst_d_v", d_if.V_CNT, 524);
    check("rst_d_pixel", d_if.PIXEL, 0);
    check("rst_d_hs", d_if.VGA_HS, 1);
    check("rst_d_vs", d_if.VGA_VS, 1);
    check("rst_d_pcount", d_if.P_COUNT, 0);
    check("rst_d_strobes", {d_if.LINE_START, d_if.FRAME_START}, 0);
    check("rst_s_h", s_if.H_CNT, 7);
    check("rst_s_v", s_if.V_CNT, 5);
    check("rst_s_hs", s_if.VGA_HS, 0);
    check("rst_s_vs", s_if.VGA_VS, 1);
`ifdef VGA_FRAME_CNT_EN
    check("rst_d_frame_cnt", d_if.FRAME_CNT, 0);
`endif

    rst_n = 1'b1;
    @(negedge clk);
    check("first_d_h", d_if.H_CNT, 0);
    check("first_d_v", d_if.V_CNT, 0);
    check("first_d_pixel", d_if.PIXEL, 1);
    check("first_d_pcount", d_if.P_COUNT, 0);
    check("first_d_fs", d_if.FRAME_START, 1);
    check("first_d_ls", d_if.LINE_START, 1);
    check("first_s_pos", {s_if.H_CNT, s_if.V_CNT}, 0);
    check("first_s_fs", s_if.FRAME_START, 1);
`ifdef VGA_FRAME_CNT_EN
    check("first_d_frame_cnt", d_if.FRAME_CNT, 1);
    check("first_s_frame_cnt", s_if.FRAME_CNT, 1);
`endif

    // One full default line with CE=1 (the small instance runs ~16 frames meanwhile)
    d_hs_low = 0; d_hs_first = -1; d_hs_last = -1; d_pix_cnt = 0; d_pix_off_first = -1;
    d_p639 = -1; d_p799 = -1; d_vs_low = 0; d_ls_sum = 0; d_fs_sum = 0;
    s_hs_err = 0; s_vs_err = 0; s_pix_err = 0; s_pmax = 0; s_fs_cnt = 0; s_ls_cnt = 0;
    s_gap_err = 0; s_last_fs = -1; s_wrap_err = 0; s_p_3_2 = -1; s_p_0_1 = -1; s_p_7_5 = -1;
    for (int i = 0; i < 800; i++) begin
      if (d_if.VGA_HS == 1'b0) begin
        d_hs_low++;
        if (d_hs_first < 0) d_hs_first = int'(d_if.H_CNT);
        d_hs_last = int'(d_if.H_CNT);
      end
      if (d_if.PIXEL) d_pix_cnt++;
      else if (d_pix_off_first < 0) d_pix_off_first = int'(d_if.H_CNT);
      if (d_if.H_CNT == 639) d_p639 = int'(d_if.P_COUNT);
      if (d_if.H_CNT == 799) d_p799 = int'(d_if.P_COUNT);
      if (d_if.VGA_VS == 1'b0) d_vs_low++;
      d_ls_sum += int'(d_if.LINE_START);
      d_fs_sum += int'(d_if.FRAME_START);

      if (s_if.VGA_HS != ((s_if.H_CNT >= 5) && (s_if.H_CNT <= 6))) s_hs_err++;
      if (s_if.VGA_VS != (s_if.V_CNT != 4)) s_vs_err++;
      if (s_if.PIXEL != ((s_if.H_CNT < 4) && (s_if.V_CNT < 3))) s_pix_err++;
      if (int'(s_if.P_COUNT) > s_pmax) s_pmax = int'(s_if.P_COUNT);
      if (s_if.H_CNT == 3 && s_if.V_CNT == 2) s_p_3_2 = int'(s_if.P_COUNT);
      if (s_if.H_CNT == 0 && s_if.V_CNT == 1) s_p_0_1 = int'(s_if.P_COUNT);
      if (s_if.H_CNT == 7 && s_if.V_CNT == 5) s_p_7_5 = int'(s_if.P_COUNT);
      if (s_if.LINE_START) s_ls_cnt++;
      if (s_if.FRAME_START) begin
        if (s_last_fs >= 0 && (i - s_last_fs) != 48) s_gap_err++;
        if (s_if.P_COUNT != 0) s_wrap_err++;
        s_last_fs = i;
        s_fs_cnt++;
      end
      @(negedge clk);
    end
    check("d_hs_low_clocks", d_hs_low, 96);
    check("d_hs_first", d_hs_first, 656);
    check("d_hs_last", d_hs_last, 751);
    check("d_pixel_count", d_pix_cnt, 640);
    check("d_pixel_off_first", d_pix_off_first, 640);
    check("d_pcount_639_0", d_p639, 639);
    check("d_pcount_799_0", d_p799, 639);
    check("d_vs_low_line0", d_vs_low, 0);
    check("d_ls_per_line", d_ls_sum, 1);
    check("d_fs_per_line", d_fs_sum, 1);
    check("d_pos_line1", {d_if.H_CNT, d_if.V_CNT}, {10'd0, 10'd1});
    check("d_pcount_0_1", d_if.P_COUNT, 640);
    check("d_ls_line1", d_if.LINE_START, 1);
    check("d_fs_line1", d_if.FRAME_START, 0);
    check("s_hs_decode_err", s_hs_err, 0);
    check("s_vs_decode_err", s_vs_err, 0);
    check("s_pixel_decode_err", s_pix_err, 0);
    check("s_pcount_max", s_pmax, 11);
    check("s_pcount_3_2", s_p_3_2, 11);
    check("s_pcount_0_1", s_p_0_1, 4);
    check("s_pcount_7_5", s_p_7_5, 11);
    check("s_pcount_wrap_err", s_wrap_err, 0);
    check("s_fs_count", s_fs_cnt, 17);
    check("s_fs_gap_err", s_gap_err, 0);
    check("s_ls_count", s_ls_cnt, 100);
`ifdef VGA_FRAME_CNT_EN
    check("s_frame_cnt", s_if.FRAME_CNT, 17);
`endif

    // CE toggling 1,0,1,0: steps every other clock, strobes stay one clock wide
    d_moves = 0; s_moves = 0; s_width_err = 0; s_ls_width_err = 0;
    s_fs_cnt = 0; s_ls_cnt = 0; s_gap_err = 0; s_last_fs = -1;
    d_prev_h = d_if.H_CNT; s_prev_h = s_if.H_CNT;
    s_prev_fs = s_if.FRAME_START; s_prev_ls = s_if.LINE_START;
    for (int i = 0; i < 300; i++) begin
      ce = (i % 2 == 0);
      @(negedge clk);
      if (d_if.H_CNT != d_prev_h) d_moves++;
      if (s_if.H_CNT != s_prev_h) s_moves++;
      if (s_if.FRAME_START && s_prev_fs) s_width_err++;
      if (s_if.LINE_START && s_prev_ls) s_ls_width_err++;
      if (s_if.LINE_START) s_ls_cnt++;
      if (s_if.FRAME_START) begin
        if (s_last_fs >= 0 && (i - s_last_fs) != 96) s_gap_err++;
        s_last_fs = i;
        s_fs_cnt++;
      end
      d_prev_h = d_if.H_CNT; s_prev_h = s_if.H_CNT;
      s_prev_fs = s_if.FRAME_START; s_prev_ls = s_if.LINE_START;
    end
    ce = 1'b1;
    check("ce_d_moves", d_moves, 150);
    check("ce_s_moves", s_moves, 150);
    check("ce_s_fs_width_err", s_width_err, 0);
    check("ce_s_ls_width_err", s_ls_width_err, 0);
    check("ce_s_ls_count", s_ls_cnt, 18);
    check("ce_s_fs_count", s_fs_cnt, 3);
    check("ce_s_fs_gap_err", s_gap_err, 0);
    check("ce_d_pos", {d_if.H_CNT, d_if.V_CNT}, {10'd150, 10'd1});

    // Reset mid-frame at (300,2)
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      if (d_if.H_CNT == 300 && d_if.V_CNT == 2) found = 1'b1;
      else @(negedge clk);
    end
    check("wait_300_2", found, 1);
    check("mid_d_pixel_before", d_if.PIXEL, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_d_h", d_if.H_CNT, 799);
    check("async_d_v", d_if.V_CNT, 524);
    check("async_d_pixel", d_if.PIXEL, 0);
    check("async_d_pcount", d_if.P_COUNT, 0);
    check("async_d_sync", {d_if.VGA_HS, d_if.VGA_VS}, 3);
`ifdef VGA_FRAME_CNT_EN
    check("async_d_frame_cnt", d_if.FRAME_CNT, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_d_pos", {d_if.H_CNT, d_if.V_CNT}, 0);
    check("rel_d_pixel", d_if.PIXEL, 1);
    check("rel_d_pcount", d_if.P_COUNT, 0);
    check("rel_d_strobes", {d_if.LINE_START, d_if.FRAME_START}, 3);
`ifdef VGA_FRAME_CNT_EN
    check("rel_d_frame_cnt", d_if.FRAME_CNT, 1);
`endif
    @(negedge clk);
    check("rel2_d_h", d_if.H_CNT, 1);
    check("rel2_d_pcount", d_if.P_COUNT, 1);
    check("rel2_d_strobes", {d_if.LINE_START, d_if.FRAME_START}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
